// File: rtl/time_pkg.sv
// time_pkg
// Shared definitions for the sequential BCD time adder.
//   state_t      : controller states (IDLE, ADD, FIX, DONE)
//   TIME_W       : width of a packed HH:MM:SS value (six BCD digits)
//   bcd_digit_t  : one 4-bit BCD digit
//   DIGIT_RADIX  : per-digit radix, element 0 = S1 ... element 5 = H10
package time_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int TIME_W = 24;

  typedef logic [3:0] bcd_digit_t;

  // Packed so element [0] is the rightmost entry: {H10, H1, M10, M1, S10, S1}.
  localparam logic [5:0][3:0] DIGIT_RADIX = {4'd10, 4'd10, 4'd6, 4'd10, 4'd6, 4'd10};

endpackage

// File: rtl/bcd_digit_add.sv
// bcd_digit_add
// Combinational single-digit adder with a selectable radix (10 or 6).
// Ports:
//   a, b   in  4  operand digits
//   cin    in  1  carry from the next lower digit
//   radix  in  4  radix of this digit position
//   digit  out 4  result digit
//   cout   out 1  carry into the next higher digit
module bcd_digit_add
  import time_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  input  bcd_digit_t radix,
  output bcd_digit_t digit,
  output logic       cout
);

  logic [4:0] total;

  // Five bits hold any a+b+cin, so the compare against the radix never wraps.
  assign total = {1'b0, a} + {1'b0, b} + {4'd0, cin};

  // A single subtraction of the radix is enough for legal digits; illegal
  // digits still give a fixed, repeatable result because the difference is
  // simply truncated to four bits.
  always_comb begin
    digit = total[3:0];
    cout  = 1'b0;
    if (total >= {1'b0, radix}) begin
      digit = 4'(total - {1'b0, radix});
      cout  = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_time_adder_seq.sv
// bcd_time_adder_seq
// Adds two HH:MM:SS BCD values one digit per clock (S1 first, H10 last),
// then applies an hour ceiling by wrapping or saturating.
// Parameters:
//   HOUR_MAX  largest legal hour (1..99)
//   WRAP      0 = saturate to HOUR_MAX:59:59, 1 = wrap modulo HOUR_MAX+1
// Ports:
//   clock      in  1   rising-edge clock
//   reset      in  1   asynchronous, active-high
//   start      in  1   launch request, only looked at while idle
//   a_time     in  24  operand A {H10,H1,M10,M1,S10,S1}
//   b_time     in  24  operand B, same layout
//   busy       out 1   high from acceptance through the done cycle
//   done       out 1   one-cycle pulse, sum valid
//   sum        out 24  result, held until the next result write
//   carry_out  out 1   hour ceiling was exceeded by the last sum
//   error      out 1   invalid operand (only with TIME_ADDER_CHECK_EN)
// Build option:
//   TIME_ADDER_CHECK_EN  validates operands on capture; without it error is 0.
module bcd_time_adder_seq
  import time_pkg::*;
#(
  parameter int HOUR_MAX = 99,
  parameter int WRAP     = 0
)(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [TIME_W-1:0] a_time,
  input  logic [TIME_W-1:0] b_time,
  output logic              busy,
  output logic              done,
  output logic [TIME_W-1:0] sum,
  output logic              carry_out,
  output logic              error
);

  localparam logic [7:0]        HOUR_MAX_B = 8'(HOUR_MAX);
  localparam logic [7:0]        HOUR_LIMIT = 8'(HOUR_MAX + 1);
  localparam logic [TIME_W-1:0] SAT_SUM    = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10), 16'h5959};

  state_t            state;
  logic [TIME_W-1:0] a_reg;
  logic [TIME_W-1:0] b_reg;
  logic [TIME_W-1:0] acc;
  logic              carry;
  logic [2:0]        idx;

  bcd_digit_t dig_a;
  bcd_digit_t dig_b;
  bcd_digit_t dig_radix;
  bcd_digit_t dig_sum;
  logic       dig_cout;

  logic [7:0]        hours_bin;
  logic [7:0]        hours_wrap;
  bcd_digit_t        wrap_tens;
  bcd_digit_t        wrap_ones;
  logic [TIME_W-1:0] fix_sum;
  logic              fix_carry;

  // Select the operand digits and radix for the digit index being added, so
  // one digit adder serves all six positions.
  always_comb begin
    dig_a     = a_reg[3:0];
    dig_b     = b_reg[3:0];
    dig_radix = DIGIT_RADIX[0];
    for (int i = 1; i < 6; i++) begin
      if (idx == 3'(i)) begin
        dig_a     = a_reg[4*i +: 4];
        dig_b     = b_reg[4*i +: 4];
        dig_radix = DIGIT_RADIX[i];
      end
    end
  end

  bcd_digit_add u_digit (
    .a     (dig_a),
    .b     (dig_b),
    .cin   (carry),
    .radix (dig_radix),
    .digit (dig_sum),
    .cout  (dig_cout)
  );

  // Hour correction. The carry left over from H10 is worth 100 hours, so the
  // full hour count is rebuilt in binary before comparing with the ceiling.
  // One subtraction of HOUR_MAX+1 covers every sum of two legal operands.
  always_comb begin
    hours_bin  = (carry ? 8'd100 : 8'd0) + 8'(acc[23:20]) * 8'd10 + 8'(acc[19:16]);
    hours_wrap = hours_bin - HOUR_LIMIT;
    wrap_tens  = 4'(hours_wrap / 8'd10);
    wrap_ones  = 4'(hours_wrap % 8'd10);
    fix_sum    = acc;
    fix_carry  = 1'b0;
    if (hours_bin > HOUR_MAX_B) begin
      fix_carry = 1'b1;
      if (WRAP != 0) begin
        fix_sum = {wrap_tens, wrap_ones, acc[15:0]};
      end else begin
        fix_sum = SAT_SUM;
      end
    end
  end

`ifdef TIME_ADDER_CHECK_EN
  logic a_ok;
  logic b_ok;

  // Operand check: every digit within its radix and the hour field within
  // the ceiling. Hours are only trusted once both hour digits are below 10.
  function automatic logic time_ok(input logic [TIME_W-1:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (t[4*i +: 4] >= DIGIT_RADIX[i]) begin
        ok = 1'b0;
      end
    end
    if (ok && ((8'(t[23:20]) * 8'd10 + 8'(t[19:16])) > HOUR_MAX_B)) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  assign a_ok = time_ok(a_time);
  assign b_ok = time_ok(b_time);
`else
  assign error = 1'b0;
`endif

  // Controller. IDLE captures operands, ADD walks the six digits while
  // carrying, FIX writes the corrected result, DONE emits the pulse. All
  // handshake outputs are registered here so they change only on edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      idx       <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef TIME_ADDER_CHECK_EN
      error     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_time;
            b_reg <= b_time;
            acc   <= '0;
            carry <= 1'b0;
            idx   <= 3'd0;
            busy  <= 1'b1;
`ifdef TIME_ADDER_CHECK_EN
            if (a_ok && b_ok) begin
              error <= 1'b0;
              state <= ADD;
            end else begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
`else
            state <= ADD;
`endif
          end
        end
        ADD: begin
          for (int i = 0; i < 6; i++) begin
            if (idx == 3'(i)) begin
              acc[4*i +: 4] <= dig_sum;
            end
          end
          carry <= dig_cout;
          if (idx == 3'd5) begin
            state <= FIX;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        FIX: begin
          sum       <= fix_sum;
          carry_out <= fix_carry;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
